// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the neuron-controller layer sequencer.
package nn_ctrl_pkg;

  localparam int IDX_W      = 6;
  localparam int DEFAULT_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-neuron wait timer: cleared on issue, counts while waiting, flags the last allowed cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_r;

  // wait-cycle counter, held once the final cycle is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= {TW{1'b0}};
    end else if (clr) begin
      timer_r <= {TW{1'b0}};
    end else if (en && !expired) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  assign expired = en && (timer_r == TW'(TIMEOUT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Layer-level initiator: issues one start per neuron, captures each result into the
// output buffer, and aborts the layer with a sticky error if a neuron never answers.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int M       = 10,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             layer_start,
  output logic             neuron_start,
  output logic [IDX_W-1:0] neuron_idx,
  input  logic             neuron_ready,
  input  logic [DW-1:0]    neuron_result,
  output logic             out_we,
  output logic [IDX_W-1:0] out_addr,
  output logic [DW-1:0]    out_data,
  output logic             busy,
  output logic             layer_done,
  output logic             err
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [DW-1:0]    out_data_r;
  logic             err_r;
  logic             start_r;
  logic             we_r;
  logic             done_r;
  logic             busy_r;
  logic             wd_clr_s;
  logic             wd_en_s;
  logic             expired_s;
  logic             last_idx_s;

  assign wd_clr_s   = (state_r == ST_ISSUE);
  assign wd_en_s    = (state_r == ST_WAIT);
  assign last_idx_s = (idx_r == IDX_W'(M - 1));

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (expired_s)
  );

  // next-state logic; a ready in the final watchdog cycle takes priority over the abort
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (layer_start) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (neuron_ready)   state_nxt_s = ST_STORE;
        else if (expired_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_WAIT;
      end
      ST_STORE: begin
        if (last_idx_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_ISSUE;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state register with Moore outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      start_r <= 1'b0;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      start_r <= (state_nxt_s == ST_ISSUE);
      we_r    <= (state_nxt_s == ST_STORE);
      done_r  <= (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // neuron index, result capture and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r      <= {IDX_W{1'b0}};
      out_data_r <= {DW{1'b0}};
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (layer_start) begin
            idx_r <= {IDX_W{1'b0}};
            err_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (neuron_ready)   out_data_r <= neuron_result;
          else if (expired_s) err_r      <= 1'b1;
        end
        ST_STORE: begin
          if (!last_idx_s) idx_r <= idx_r + IDX_W'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign neuron_start = start_r;
  assign neuron_idx   = idx_r;
  assign out_we       = we_r;
  assign out_addr     = idx_r;
  assign out_data     = out_data_r;
  assign busy         = busy_r;
  assign layer_done   = done_r;
  assign err          = err_r;

endmodule
